// File: rtl/pinball_pkg.sv
// Shared pinball encodings: game states, target group masks/points.
// Also used by the LED_control and score display stages.
package pinball_pkg;

  localparam int SCORE_W = 15;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_GET   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // bit i of an entry = target slot i belongs to that group
  localparam logic [7:0] GROUP_MASK [8] = '{
    8'hAA, 8'h92, 8'h48, 8'h04,
    8'h55, 8'h49, 8'h12, 8'h20
  };

  // fewer slots in a group -> harder to hit -> more points
  localparam logic [5:0] GROUP_POINTS [8] = '{
    6'd5, 6'd10, 6'd20, 6'd40,
    6'd5, 6'd10, 6'd20, 6'd40
  };

  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [5:0]         b
  );
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-5){1'b0}}, b};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/pinball_tick_gen.sv
// LED step tick: one-cycle o_tick every TICK_DIV clock cycles.
// Ports: clk, reset (async, high), o_tick (registered pulse).
module pinball_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
      r_tick <= w_wrap;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/pinball_game_ctrl.sv
// Pinball game sequencer: FSM, score, target group rotation, LED tick.
// Ports: clk, reset (async, high); btn_start, hit_valid, hit_slot[2:0],
// ball_lost in; state[2:0], selected_group[7:0], score[14:0], win,
// led_clk out (all registered).
module pinball_game_ctrl
  import pinball_pkg::*;
#(
  parameter int                  TICK_DIV     = 5_000_000,
  parameter int                  GROUP_PERIOD = 4,
  parameter int                  GET_HOLD     = 8,
  parameter int                  BALLS        = 3,
  parameter logic [SCORE_W-1:0]  WIN_SCORE    = 15'd1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               hit_valid,
  input  logic [2:0]         hit_slot,
  input  logic               ball_lost,
  output logic [2:0]         state,
  output logic [7:0]         selected_group,
  output logic [SCORE_W-1:0] score,
  output logic               win,
  output logic               led_clk
);

  localparam int GW = $clog2(GROUP_PERIOD + 1);
  localparam int HW = $clog2(GET_HOLD + 1);

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_group, w_group_nxt;
  logic [GW-1:0]      r_grp_cnt, w_grp_cnt_nxt;
  logic [HW-1:0]      r_hold, w_hold_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic               r_win, w_win_nxt;
  logic [2:0]         r_balls, w_balls_nxt;

  logic               w_tick;
  logic               w_hit;
  logic [SCORE_W-1:0] w_sum;
  logic               w_won;
  logic               w_last;

  pinball_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .o_tick(w_tick)
  );

  assign w_hit  = hit_valid & GROUP_MASK[r_group][hit_slot];
  assign w_sum  = sat_add(r_score, GROUP_POINTS[r_group]);
  assign w_won  = (w_sum >= WIN_SCORE);
  assign w_last = (r_balls == 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_group   <= '0;
      r_grp_cnt <= '0;
      r_hold    <= '0;
      r_score   <= '0;
      r_win     <= 1'b0;
      r_balls   <= 3'(BALLS);
    end else begin
      r_group   <= w_group_nxt;
      r_grp_cnt <= w_grp_cnt_nxt;
      r_hold    <= w_hold_nxt;
      r_score   <= w_score_nxt;
      r_win     <= w_win_nxt;
      r_balls   <= w_balls_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_group_nxt   = r_group;
    w_grp_cnt_nxt = r_grp_cnt;
    w_hold_nxt    = '0;
    w_score_nxt   = r_score;
    w_win_nxt     = r_win;
    w_balls_nxt   = r_balls;

    // target rotation only while a ball is waiting or in play
    if ((r_state == ST_WAIT || r_state == ST_START) && w_tick) begin
      if (r_grp_cnt == GW'(GROUP_PERIOD - 1)) begin
        w_group_nxt   = r_group + 3'd1;
        w_grp_cnt_nxt = '0;
      end else begin
        w_grp_cnt_nxt = r_grp_cnt + GW'(1);
      end
    end

    case (r_state)
      ST_RESET: begin
        if (btn_start) begin
          w_state_nxt = ST_WAIT;
          w_score_nxt = '0;
          w_win_nxt   = 1'b0;
          w_balls_nxt = 3'(BALLS);
        end
      end
      ST_WAIT: begin
        if (btn_start) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_hit) begin
          w_score_nxt = w_sum;
          if (w_won) begin
            w_state_nxt = ST_OVER;
            w_win_nxt   = 1'b1;
          end else if (ball_lost) begin
            // drain beats the GET hold; points already banked
            w_balls_nxt = r_balls - 3'd1;
            w_state_nxt = w_last ? ST_OVER : ST_WAIT;
            w_win_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_GET;
          end
        end else if (ball_lost) begin
          w_balls_nxt = r_balls - 3'd1;
          w_state_nxt = w_last ? ST_OVER : ST_WAIT;
          w_win_nxt   = 1'b0;
        end
      end
      ST_GET: begin
        if (ball_lost) begin
          w_balls_nxt = r_balls - 3'd1;
          w_state_nxt = w_last ? ST_OVER : ST_WAIT;
          w_win_nxt   = 1'b0;
        end else if (w_tick) begin
          if (r_hold == HW'(GET_HOLD - 1)) begin
            w_state_nxt = ST_START;
          end else begin
            w_hold_nxt = r_hold + HW'(1);
          end
        end else begin
          w_hold_nxt = r_hold;
        end
      end
      ST_OVER: begin
        if (btn_start) begin
          w_state_nxt = ST_RESET;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  assign state          = r_state;
  assign selected_group = {5'b0, r_group};
  assign score          = r_score;
  assign win            = r_win;
  assign led_clk        = w_tick;

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Directed bench for pinball_game_ctrl.
// Second instance exercises score saturation at 15'h7FFF.
module tb_pinball_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_start, hit_valid, ball_lost;
  logic [2:0]  hit_slot;
  logic [2:0]  state;
  logic [7:0]  selected_group;
  logic [14:0] score;
  logic        win, led_clk;

  logic        btn2, hit2;
  logic [2:0]  state2;
  logic [7:0]  group2;
  logic [14:0] score2;
  logic        win2, led2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pinball_game_ctrl #(
    .TICK_DIV(4), .GROUP_PERIOD(2), .GET_HOLD(2),
    .BALLS(2), .WIN_SCORE(15'd50)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .hit_valid(hit_valid),
    .hit_slot(hit_slot), .ball_lost(ball_lost),
    .state(state), .selected_group(selected_group),
    .score(score), .win(win), .led_clk(led_clk)
  );

  pinball_game_ctrl #(
    .TICK_DIV(2), .GROUP_PERIOD(1_000_000), .GET_HOLD(1),
    .BALLS(1), .WIN_SCORE(15'h7FFF)
  ) dut2 (
    .clk(clk), .reset(reset),
    .btn_start(btn2), .hit_valid(hit2),
    .hit_slot(3'd1), .ball_lost(1'b0),
    .state(state2), .selected_group(group2),
    .score(score2), .win(win2), .led_clk(led2)
  );

  task automatic press_start();
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic press_start2();
    btn2 = 1'b1;
    @(negedge clk);
    btn2 = 1'b0;
  endtask

  task automatic do_hit(input logic [2:0] s, input logic lost);
    hit_valid = 1'b1;
    hit_slot  = s;
    ball_lost = lost;
    @(negedge clk);
    hit_valid = 1'b0;
    ball_lost = 1'b0;
  endtask

  task automatic do_lost();
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
  endtask

  // stop in START on group g with no tick pending at the next edge
  task automatic wait_group(input logic [2:0] g);
    int n;
    n = 0;
    while (!(selected_group[2:0] == g && state == 3'd2 && !led_clk)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_group timeout got grp=%0d st=%0d want grp=%0d",
               selected_group, state, g);
    end
  endtask

  task automatic test_reset();
    int pulses, first;
    reset = 1'b1;
    btn_start = 0; hit_valid = 0; ball_lost = 0; hit_slot = 0;
    btn2 = 0; hit2 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({state, selected_group, score, win, led_clk} !== 29'd0) begin
      errors++;
      $display("FAIL reset_vals got st=%0d grp=%0d sc=%0d w=%0d l=%0d want 0",
               state, selected_group, score, win, led_clk);
    end
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (led_clk) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    checks++;
    if (pulses != 5 || first != 4) begin
      errors++;
      $display("FAIL led_clk got pulses=%0d first=%0d want 5 and 4",
               pulses, first);
    end
    checks++;
    if (state !== 3'd0 || score !== 15'd0 || selected_group !== 8'd0) begin
      errors++;
      $display("FAIL idle got st=%0d sc=%0d grp=%0d want 0 0 0",
               state, score, selected_group);
    end
  endtask

  task automatic test_rotation();
    logic [2:0] prev;
    int n;
    bit wrapped;
    press_start();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL to_wait got %0d want 1", state);
    end
    press_start();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL to_start got %0d want 2", state);
    end
    prev = selected_group[2:0];
    n = 0;
    while (selected_group[2:0] == prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    wrapped = 0;
    for (int k = 0; k < 9; k++) begin
      prev = selected_group[2:0];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (selected_group[2:0] == prev && n < 20);
      checks++;
      if (n != 8 || selected_group !== {5'b0, 3'(prev + 3'd1)}) begin
        errors++;
        $display("FAIL rotate got grp=%0d after %0d want %0d after 8",
                 selected_group, n, 3'(prev + 3'd1));
      end
      if (selected_group == 8'd0) wrapped = 1;
    end
    checks++;
    if (!wrapped) begin
      errors++;
      $display("FAIL wrap got no 7->0 want wrap");
    end
  endtask

  task automatic test_hit_get();
    int n, ticks;
    wait_group(3'd3);
    do_hit(3'd2, 1'b0);
    checks++;
    if (score !== 15'd40 || state !== 3'd3) begin
      errors++;
      $display("FAIL hit40 got sc=%0d st=%0d want 40 3", score, state);
    end
    n = 0;
    ticks = 0;
    while (state == 3'd3 && n < 40) begin
      if (led_clk) ticks++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (ticks != 2 || state !== 3'd2) begin
      errors++;
      $display("FAIL get_hold got ticks=%0d st=%0d want 2 2", ticks, state);
    end
    wait_group(3'd3);
    do_hit(3'd5, 1'b0);
    checks++;
    if (score !== 15'd40 || state !== 3'd2) begin
      errors++;
      $display("FAIL miss got sc=%0d st=%0d want 40 2", score, state);
    end
  endtask

  task automatic test_balls();
    do_lost();
    checks++;
    if (state !== 3'd1 || score !== 15'd40) begin
      errors++;
      $display("FAIL lost1 got st=%0d sc=%0d want 1 40", state, score);
    end
    press_start();
    do_lost();
    checks++;
    if (state !== 3'd4 || win !== 1'b0 || score !== 15'd40) begin
      errors++;
      $display("FAIL lost2 got st=%0d w=%0d sc=%0d want 4 0 40",
               state, win, score);
    end
    press_start();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL restart got %0d want 0", state);
    end
    press_start();
    checks++;
    if (state !== 3'd1 || score !== 15'd0 || win !== 1'b0) begin
      errors++;
      $display("FAIL newgame got st=%0d sc=%0d w=%0d want 1 0 0",
               state, score, win);
    end
  endtask

  task automatic test_win();
    press_start();
    wait_group(3'd3);
    do_hit(3'd2, 1'b1);
    checks++;
    if (score !== 15'd40 || state !== 3'd1) begin
      errors++;
      $display("FAIL hit_lost got sc=%0d st=%0d want 40 1", score, state);
    end
    press_start();
    wait_group(3'd3);
    do_hit(3'd2, 1'b1);
    checks++;
    if (score !== 15'd80 || state !== 3'd4 || win !== 1'b1) begin
      errors++;
      $display("FAIL win got sc=%0d st=%0d w=%0d want 80 4 1",
               score, state, win);
    end
    do_lost();
    do_hit(3'd2, 1'b0);
    checks++;
    if (score !== 15'd80 || state !== 3'd4 || win !== 1'b1) begin
      errors++;
      $display("FAIL over_hold got sc=%0d st=%0d w=%0d want 80 4 1",
               score, state, win);
    end
  endtask

  task automatic test_saturate();
    int hits, iter, model;
    press_start2();
    press_start2();
    checks++;
    if (state2 !== 3'd2) begin
      errors++;
      $display("FAIL sat_start got %0d want 2", state2);
    end
    hits = 0;
    iter = 0;
    model = 0;
    while (state2 != 3'd4 && iter < 60000) begin
      if (state2 == 3'd2) begin
        hit2 = 1'b1;
        @(negedge clk);
        hit2 = 1'b0;
        hits++;
        model = (model + 5 > 32767) ? 32767 : model + 5;
      end else begin
        @(negedge clk);
      end
      iter++;
    end
    checks++;
    if (score2 !== 15'h7FFF || state2 !== 3'd4 || win2 !== 1'b1) begin
      errors++;
      $display("FAIL sat got sc=%h st=%0d w=%0d want 7fff 4 1",
               score2, state2, win2);
    end
    checks++;
    if (hits != 6554 || int'(score2) != model) begin
      errors++;
      $display("FAIL sat_hits got hits=%0d sc=%0d want 6554 %0d",
               hits, score2, model);
    end
  endtask

  task automatic test_reset_mid_get();
    press_start();
    press_start();
    press_start();
    wait_group(3'd3);
    do_hit(3'd2, 1'b0);
    checks++;
    if (state !== 3'd3 || score !== 15'd40) begin
      errors++;
      $display("FAIL pre_rst got st=%0d sc=%0d want 3 40", state, score);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, selected_group, score, win, led_clk} !== 29'd0) begin
      errors++;
      $display("FAIL async_rst got st=%0d grp=%0d sc=%0d w=%0d l=%0d want 0",
               state, selected_group, score, win, led_clk);
    end
    checks++;
    if (state2 !== 3'd0 || score2 !== 15'd0 || win2 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst2 got st=%0d sc=%0d w=%0d want 0 0 0",
               state2, score2, win2);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_hit_get();
    test_balls();
    test_win();
    test_saturate();
    test_reset_mid_get();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
